coco3_mem_arbiter: RTL and testbench

- Shares one 16-bit-wide external memory port, fronted by the SDRAM controller, between three requesters: the ROM/disk download loader (ioctl path), the video fetch engine and the 6809 CPU bus.
- Sits between the coco3fpga core's memory requesters and the SDRAM controller.
- Sequences one transaction at a time with fixed priority loader > video > CPU.
- Applies a per-transaction ack timeout so a stalled memory never hangs the core.

---
 rtl/coco3_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_coco3_mem_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coco3_mem_arbiter.sv
// coco3_mem_arbiter: one-at-a-time arbiter (loader > video > CPU) onto a 16-bit SDRAM port with ack timeout.
// Optional macro COCO3_ARB_STARVE_EN lets a long-waiting CPU outrank video.
module coco3_mem_arbiter #(
    parameter int AW           = 21,
    parameter int TIMEOUT      = 255,
    parameter int CPU_MAX_WAIT = 64
) (
    input  logic          CLK50MHZ,
    input  logic          COCO_RESET_N,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [7:0]    CPU_DIN,
    output logic [7:0]    CPU_DOUT,
    output logic          CPU_ACK,
    input  logic          VID_REQ,
    input  logic [AW-2:0] VID_ADDR,
    output logic [15:0]   VID_DOUT,
    output logic          VID_ACK,
    input  logic          DL_REQ,
    input  logic [AW-1:0] DL_ADDR,
    input  logic [7:0]    DL_DIN,
    output logic          DL_ACK,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-2:0] MEM_ADDR,
    output logic [15:0]   MEM_DIN,
    output logic [1:0]    MEM_BE,
    input  logic [15:0]   MEM_DOUT,
    input  logic          MEM_ACK,
    output logic          ERR
);
    // state | meaning
    // IDLE  | evaluate priority, launch granted transaction
    // BUSY  | MEM_REQ held, waiting for MEM_ACK or timeout
    // DONE  | granted requester's ACK high for this one cycle
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {G_DL, G_VID, G_CPU} grant_t;

    // one width covers both the ack timer and the CPU wait counter
    localparam int CW = $clog2(((TIMEOUT > CPU_MAX_WAIT) ? TIMEOUT : CPU_MAX_WAIT) + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    grant_t        grant;
    grant_t        pick;
    logic          pick_valid;
    logic          cpu_first;
    logic          lane;
    logic [CW-1:0] tcnt;
    logic [15:0]   rdata;

    always_comb begin
        pick       = G_DL;
        pick_valid = 1'b1;
        if (DL_REQ)                    pick = G_DL;
        else if (CPU_REQ && cpu_first) pick = G_CPU;
        else if (VID_REQ)              pick = G_VID;
        else if (CPU_REQ)              pick = G_CPU;
        else                           pick_valid = 1'b0;
    end

`ifdef COCO3_ARB_STARVE_EN
    localparam logic [CW-1:0] WAIT_MAX = CW'(CPU_MAX_WAIT);
    logic [CW-1:0] wait_cnt;

    assign cpu_first = (wait_cnt == WAIT_MAX);

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            wait_cnt <= '0;
        end else if (state == IDLE && pick_valid) begin
            if (pick == G_CPU)
                wait_cnt <= '0;
            else if (pick == G_VID && CPU_REQ && !cpu_first)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign cpu_first = 1'b0;
`endif

    // a timed-out read returns all ones
    assign rdata = MEM_ACK ? MEM_DOUT : 16'hFFFF;

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            state    <= IDLE;
            grant    <= G_DL;
            lane     <= 1'b0;
            tcnt     <= '0;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DIN  <= '0;
            MEM_BE   <= '0;
            CPU_DOUT <= '0;
            VID_DOUT <= '0;
            CPU_ACK  <= 1'b0;
            VID_ACK  <= 1'b0;
            DL_ACK   <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            CPU_ACK <= 1'b0;
            VID_ACK <= 1'b0;
            DL_ACK  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick;
                        tcnt    <= '0;
                        MEM_REQ <= 1'b1;
                        state   <= BUSY;
                        case (pick)
                            G_DL: begin
                                MEM_WE   <= 1'b1;
                                MEM_ADDR <= DL_ADDR[AW-1:1];
                                MEM_DIN  <= {DL_DIN, DL_DIN};
                                MEM_BE   <= DL_ADDR[0] ? 2'b01 : 2'b10;
                                lane     <= DL_ADDR[0];
                            end
                            G_VID: begin
                                MEM_WE   <= 1'b0;
                                MEM_ADDR <= VID_ADDR;
                                MEM_DIN  <= '0;
                                MEM_BE   <= 2'b11;
                                lane     <= 1'b0;
                            end
                            default: begin
                                MEM_WE   <= CPU_WE;
                                MEM_ADDR <= CPU_ADDR[AW-1:1];
                                MEM_DIN  <= {CPU_DIN, CPU_DIN};
                                MEM_BE   <= !CPU_WE ? 2'b11 : (CPU_ADDR[0] ? 2'b01 : 2'b10);
                                lane     <= CPU_ADDR[0];
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (MEM_ACK || tcnt == TO_LAST) begin
                        MEM_REQ <= 1'b0;
                        state   <= DONE;
                        if (!MEM_ACK)
                            ERR <= 1'b1;
                        case (grant)
                            G_DL:  DL_ACK <= 1'b1;
                            G_VID: begin
                                VID_ACK  <= 1'b1;
                                VID_DOUT <= rdata;
                            end
                            default: begin
                                CPU_ACK <= 1'b1;
                                if (!MEM_WE)
                                    CPU_DOUT <= lane ? rdata[7:0] : rdata[15:8];
                            end
                        endcase
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coco3_mem_arbiter.sv
// Bench for coco3_mem_arbiter: requester agents, an SDRAM responder and a byte-level memory model.
module tb_coco3_mem_arbiter;
    localparam int TIMEOUT = 255;
    localparam int MAXW    = 4;
`ifdef COCO3_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        CLK50MHZ = 1'b0;
    logic        COCO_RESET_N = 1'b0;
    logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
    logic [20:0] CPU_ADDR = '0;
    logic [7:0]  CPU_DIN = '0;
    logic [7:0]  CPU_DOUT;
    logic        CPU_ACK;
    logic        VID_REQ = 1'b0;
    logic [19:0] VID_ADDR = '0;
    logic [15:0] VID_DOUT;
    logic        VID_ACK;
    logic        DL_REQ = 1'b0;
    logic [20:0] DL_ADDR = '0;
    logic [7:0]  DL_DIN = '0;
    logic        DL_ACK;
    logic        MEM_REQ, MEM_WE;
    logic [19:0] MEM_ADDR;
    logic [15:0] MEM_DIN;
    logic [1:0]  MEM_BE;
    logic [15:0] MEM_DOUT = '0;
    logic        MEM_ACK = 1'b0;
    logic        ERR;

    coco3_mem_arbiter #(.AW(21), .TIMEOUT(TIMEOUT), .CPU_MAX_WAIT(MAXW)) dut (
        .CLK50MHZ(CLK50MHZ), .COCO_RESET_N(COCO_RESET_N),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT), .CPU_ACK(CPU_ACK),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DOUT(VID_DOUT), .VID_ACK(VID_ACK),
        .DL_REQ(DL_REQ), .DL_ADDR(DL_ADDR), .DL_DIN(DL_DIN), .DL_ACK(DL_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_BE(MEM_BE), .MEM_DOUT(MEM_DOUT), .MEM_ACK(MEM_ACK), .ERR(ERR)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    typedef struct {bit we; logic [20:0] addr; logic [7:0] din;} req_t;
    typedef struct {
        int who; req_t r; logic [15:0] rdata; logic [2:0] snap;
        bit g_we; logic [19:0] g_addr; logic [1:0] g_be; logic [15:0] g_din;
        int lat; int mreq;
    } rec_t;

    req_t dl_q[$], vid_q[$], cpu_q[$];
    rec_t comp_q[$];
    req_t cur_dl, cur_vid, cur_cpu;
    logic [15:0] sdram [logic [19:0]];
    logic [7:0]  ref_mem [int];

    int tests = 0, fails = 0;
    int cyc = 0, t_dl, t_vid, t_cpu;
    bit ack_en = 1'b1, rand_delay = 1'b1;
    int ack_delay = 0, age = 0, mreq_cnt = 0;
    bit prev_mreq = 1'b0;
    logic [2:0] snap = '0, g_snap = '0;
    bit g_we; logic [19:0] g_addr; logic [1:0] g_be; logic [15:0] g_din;

    function automatic rec_t mk_rec(int who, req_t r, logic [15:0] d, int t0);
        rec_t x;
        x.who = who; x.r = r; x.rdata = d; x.snap = g_snap;
        x.g_we = g_we; x.g_addr = g_addr; x.g_be = g_be; x.g_din = g_din;
        x.lat = cyc - t0; x.mreq = mreq_cnt;
        return x;
    endfunction

    function automatic logic [7:0] refb(int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // requester agents and SDRAM responder share one process, acting 1 time unit after each edge
    initial begin : env
        logic [15:0] w;
        forever begin
            @(posedge CLK50MHZ); #1;
            cyc++;
            if (DL_ACK)  begin comp_q.push_back(mk_rec(0, cur_dl, 16'h0, t_dl));       DL_REQ = 1'b0;  end
            if (VID_ACK) begin comp_q.push_back(mk_rec(1, cur_vid, VID_DOUT, t_vid));  VID_REQ = 1'b0; end
            if (CPU_ACK) begin comp_q.push_back(mk_rec(2, cur_cpu, {8'h0, CPU_DOUT}, t_cpu)); CPU_REQ = 1'b0; end
            if (MEM_REQ && !prev_mreq) begin
                g_we = MEM_WE; g_addr = MEM_ADDR; g_be = MEM_BE; g_din = MEM_DIN;
                g_snap = snap; mreq_cnt = 0;
            end
            if (MEM_REQ) mreq_cnt++;
            prev_mreq = MEM_REQ;
            if (MEM_REQ) begin
                if (age == 0 && rand_delay) ack_delay = $urandom_range(0, 5);
                if (ack_en && age == ack_delay) begin
                    MEM_ACK = 1'b1;
                    w = sdram.exists(MEM_ADDR) ? sdram[MEM_ADDR] : 16'h0;
                    if (MEM_WE) begin
                        if (MEM_BE[1]) w[15:8] = MEM_DIN[15:8];
                        if (MEM_BE[0]) w[7:0]  = MEM_DIN[7:0];
                        sdram[MEM_ADDR] = w;
                        MEM_DOUT = 16'($urandom);
                    end else begin
                        MEM_DOUT = w;
                    end
                end else begin
                    MEM_ACK = 1'b0;
                end
                age++;
            end else begin
                MEM_ACK = 1'b0;
                age = 0;
            end
            if (!DL_REQ && dl_q.size() > 0) begin
                cur_dl = dl_q.pop_front(); DL_REQ = 1'b1; DL_ADDR = cur_dl.addr; DL_DIN = cur_dl.din; t_dl = cyc;
            end
            if (!VID_REQ && vid_q.size() > 0) begin
                cur_vid = vid_q.pop_front(); VID_REQ = 1'b1; VID_ADDR = cur_vid.addr[19:0]; t_vid = cyc;
            end
            if (!CPU_REQ && cpu_q.size() > 0) begin
                cur_cpu = cpu_q.pop_front(); CPU_REQ = 1'b1; CPU_WE = cur_cpu.we;
                CPU_ADDR = cur_cpu.addr; CPU_DIN = cur_cpu.din; t_cpu = cyc;
            end
            snap = {DL_REQ, VID_REQ, CPU_REQ};
        end
    end

    function automatic req_t mk_req(bit we, logic [20:0] a, logic [7:0] d);
        req_t r;
        r.we = we; r.addr = a; r.din = d;
        return r;
    endfunction

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK50MHZ);
            if (dl_q.size() == 0 && vid_q.size() == 0 && cpu_q.size() == 0 &&
                !DL_REQ && !VID_REQ && !CPU_REQ && !MEM_REQ) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK50MHZ);
        COCO_RESET_N = 1'b0;
        dl_q.delete(); vid_q.delete(); cpu_q.delete(); comp_q.delete();
        DL_REQ = 1'b0; VID_REQ = 1'b0; CPU_REQ = 1'b0;
        repeat (2) @(negedge CLK50MHZ);
        COCO_RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        rec_t r;
        int n_dl;
        @(negedge CLK50MHZ);
        COCO_RESET_N = 1'b0;
        rand_delay = 1'b1; ack_en = 1'b1;
        dl_q.push_back(mk_req(1'b1, 21'h00010, 8'h11));
        vid_q.push_back(mk_req(1'b0, 21'h00009, 8'h00));
        cpu_q.push_back(mk_req(1'b0, 21'h00013, 8'h00));
        repeat (3) @(negedge CLK50MHZ);
        tests++;
        if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE, CPU_DOUT, CPU_ACK, VID_DOUT, VID_ACK, DL_ACK, ERR} !== '0 ||
            {DL_REQ, VID_REQ, CPU_REQ} !== 3'b111) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h din=%h be=%b cdout=%h vdout=%h acks=%b err=%b, want all 0 with REQs high",
                     MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE, CPU_DOUT, VID_DOUT, {CPU_ACK, VID_ACK, DL_ACK}, ERR);
        end
        COCO_RESET_N = 1'b1;
        wait_quiet(100, ok);
        tests++;
        if (!ok || comp_q.size() != 3) begin
            fails++;
            $display("FAIL reset_release_done: got quiet=%0b records=%0d, want quiet=1 records=3", ok, comp_q.size());
        end
        n_dl = 0;
        foreach (comp_q[i]) if (comp_q[i].who == 0) n_dl++;
        tests++;
        if (n_dl != 1) begin
            fails++;
            $display("FAIL reset_dl_ack_once: got %0d DL acks, want 1", n_dl);
        end
        if (comp_q.size() == 3) begin
            tests++;
            if (comp_q[0].who != 0 || comp_q[0].g_we !== 1'b1 || comp_q[1].who != 1 || comp_q[2].who != 2) begin
                fails++;
                $display("FAIL reset_grant_order: got %0d/%0d/%0d first_we=%b, want 0/1/2 first_we=1",
                         comp_q[0].who, comp_q[1].who, comp_q[2].who, comp_q[0].g_we);
            end
        end
        while (comp_q.size() > 0) begin
            r = comp_q.pop_front();
            if (r.who == 0) ref_mem[int'(r.r.addr)] = r.r.din;
        end
    endtask

    task automatic test_cpu_write();
        bit ok;
        rec_t r;
        rand_delay = 1'b0; ack_delay = 3;
        @(negedge CLK50MHZ);
        cpu_q.push_back(mk_req(1'b1, 21'h00101, 8'h5A));
        wait_quiet(50, ok);
        tests++;
        if (!ok || comp_q.size() != 1) begin
            fails++;
            $display("FAIL cpu_write_done: got quiet=%0b records=%0d, want 1/1", ok, comp_q.size());
        end else begin
            r = comp_q.pop_front();
            ref_mem[32'h101] = 8'h5A;
            tests++;
            if (r.who != 2 || {r.g_we, r.g_addr, r.g_be, r.g_din} !== {1'b1, 20'h00080, 2'b01, 16'h5A5A}) begin
                fails++;
                $display("FAIL cpu_write_port: got who=%0d we=%b addr=%h be=%b din=%h, want 2/1/00080/01/5a5a",
                         r.who, r.g_we, r.g_addr, r.g_be, r.g_din);
            end
            tests++;
            if (r.lat != 5) begin
                fails++;
                $display("FAIL cpu_write_latency: got ack at cycle %0d, want 5", r.lat);
            end
        end
    endtask

    task automatic test_cpu_read();
        bit ok;
        rec_t r;
        logic [7:0] exp [2];
        sdram[20'h00080] = 16'hA5C3;
        ref_mem[32'h100] = 8'hA5; ref_mem[32'h101] = 8'hC3;
        exp[0] = 8'hA5; exp[1] = 8'hC3;
        rand_delay = 1'b1;
        @(negedge CLK50MHZ);
        cpu_q.push_back(mk_req(1'b0, 21'h00100, 8'h00));
        cpu_q.push_back(mk_req(1'b0, 21'h00101, 8'h00));
        wait_quiet(60, ok);
        tests++;
        if (!ok || comp_q.size() != 2) begin
            fails++;
            $display("FAIL cpu_read_done: got quiet=%0b records=%0d, want 1/2", ok, comp_q.size());
        end
        for (int i = 0; i < 2 && comp_q.size() > 0; i++) begin
            r = comp_q.pop_front();
            tests++;
            if (r.rdata[7:0] !== exp[i] || r.g_be !== 2'b11 || r.g_we !== 1'b0) begin
                fails++;
                $display("FAIL cpu_read_lane%0d: got dout=%h be=%b we=%b, want %h/11/0", i, r.rdata[7:0], r.g_be, r.g_we, exp[i]);
            end
        end
    endtask

    task automatic test_vid_priority();
        bit ok;
        @(negedge CLK50MHZ);
        vid_q.push_back(mk_req(1'b0, 21'h00080, 8'h00));
        cpu_q.push_back(mk_req(1'b0, 21'h00101, 8'h00));
        wait_quiet(60, ok);
        tests++;
        if (!ok || comp_q.size() != 2) begin
            fails++;
            $display("FAIL vid_prio_done: got quiet=%0b records=%0d, want 1/2", ok, comp_q.size());
        end else begin
            tests++;
            if (comp_q[0].who != 1 || comp_q[0].rdata !== 16'hA5C3 || comp_q[0].g_be !== 2'b11 || comp_q[0].g_we !== 1'b0) begin
                fails++;
                $display("FAIL vid_first: got who=%0d data=%h be=%b we=%b, want 1/a5c3/11/0",
                         comp_q[0].who, comp_q[0].rdata, comp_q[0].g_be, comp_q[0].g_we);
            end
            tests++;
            if (comp_q[1].who != 2 || comp_q[1].rdata[7:0] !== 8'hC3) begin
                fails++;
                $display("FAIL cpu_second: got who=%0d data=%h, want 2/c3", comp_q[1].who, comp_q[1].rdata[7:0]);
            end
        end
        comp_q.delete();
    endtask

    task automatic test_starvation();
        bit ok;
        int pos, exp_pos;
        do_reset();
        rand_delay = 1'b0; ack_delay = 1;
        cpu_q.push_back(mk_req(1'b0, 21'h00100, 8'h00));
        for (int i = 0; i < 12; i++) vid_q.push_back(mk_req(1'b0, 21'(i), 8'h00));
        wait_quiet(200, ok);
        exp_pos = STARVE ? MAXW : 12;
        pos = -1;
        foreach (comp_q[i]) if (comp_q[i].who == 2) pos = i;
        tests++;
        if (!ok || comp_q.size() != 13 || pos != exp_pos) begin
            fails++;
            $display("FAIL starvation_cpu_slot: got quiet=%0b records=%0d cpu_pos=%0d, want 1/13/%0d", ok, comp_q.size(), pos, exp_pos);
        end
        comp_q.delete();
    endtask

    task automatic test_random_traffic();
        bit ok;
        rec_t r;
        int wait_n, exp_who, a, nbad;
        logic [15:0] exp_d;
        do_reset();
        rand_delay = 1'b1; ack_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: dl_q.push_back(mk_req(1'b1, 21'($urandom_range(0, 15)), 8'($urandom)));
                1: vid_q.push_back(mk_req(1'b0, 21'($urandom_range(0, 7)), 8'h00));
                2: cpu_q.push_back(mk_req(1'b1, 21'($urandom_range(0, 15)), 8'($urandom)));
                default: cpu_q.push_back(mk_req(1'b0, 21'($urandom_range(0, 15)), 8'h00));
            endcase
            repeat ($urandom_range(0, 3)) @(negedge CLK50MHZ);
        end
        wait_quiet(2000, ok);
        tests++;
        if (!ok || comp_q.size() != 60 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL random_done: got quiet=%0b records=%0d err=%b, want 1/60/0", ok, comp_q.size(), ERR);
        end
        wait_n = 0; nbad = 0;
        while (comp_q.size() > 0) begin
            r = comp_q.pop_front();
            a = int'(r.r.addr);
            if (r.snap[2])                            exp_who = 0;
            else if (r.snap[0] && STARVE && wait_n >= MAXW) exp_who = 2;
            else if (r.snap[1])                       exp_who = 1;
            else                                      exp_who = 2;
            if (exp_who == 1 && r.snap[0] && wait_n < MAXW) wait_n++;
            if (exp_who == 2) wait_n = 0;
            tests++;
            if (r.who != exp_who) begin
                fails++; nbad++;
                $display("FAIL random_grant: got requester %0d with reqs %b, want %0d", r.who, r.snap, exp_who);
            end
            tests++;
            if (r.who == 1) begin
                exp_d = {refb(2 * a), refb(2 * a + 1)};
                if ({r.g_we, r.g_addr, r.g_be} !== {1'b0, 20'(a), 2'b11} || r.rdata !== exp_d) begin
                    fails++; nbad++;
                    $display("FAIL random_vid: got addr=%h be=%b data=%h, want %h/11/%h", r.g_addr, r.g_be, r.rdata, 20'(a), exp_d);
                end
            end else if (r.r.we) begin
                if ({r.g_we, r.g_addr, r.g_be, r.g_din} !== {1'b1, 20'(a >> 1), (a[0] ? 2'b01 : 2'b10), r.r.din, r.r.din}) begin
                    fails++; nbad++;
                    $display("FAIL random_write: got we=%b addr=%h be=%b din=%h for byte %0h=%h", r.g_we, r.g_addr, r.g_be, r.g_din, a, r.r.din);
                end
                ref_mem[a] = r.r.din;
            end else begin
                if ({r.g_we, r.g_addr, r.g_be} !== {1'b0, 20'(a >> 1), 2'b11} || r.rdata[7:0] !== refb(a)) begin
                    fails++; nbad++;
                    $display("FAIL random_cpu_read: got addr=%h be=%b data=%h, want %h/11/%h", r.g_addr, r.g_be, r.rdata[7:0], 20'(a >> 1), refb(a));
                end
            end
            if (nbad > 8) begin
                comp_q.delete();
                break;
            end
        end
    endtask

    task automatic test_ack_on_timeout();
        bit ok;
        rec_t r;
        rand_delay = 1'b0; ack_delay = TIMEOUT - 1; ack_en = 1'b1;
        @(negedge CLK50MHZ);
        cpu_q.push_back(mk_req(1'b0, 21'h00100, 8'h00));
        wait_quiet(400, ok);
        tests++;
        if (!ok || comp_q.size() != 1) begin
            fails++;
            $display("FAIL late_ack_done: got quiet=%0b records=%0d, want 1/1", ok, comp_q.size());
        end else begin
            r = comp_q.pop_front();
            tests++;
            if (r.rdata[7:0] !== refb(32'h100) || ERR !== 1'b0 || r.mreq != TIMEOUT || r.lat != TIMEOUT + 1) begin
                fails++;
                $display("FAIL late_ack: got dout=%h err=%b mreq_cycles=%0d lat=%0d, want %h/0/%0d/%0d",
                         r.rdata[7:0], ERR, r.mreq, r.lat, refb(32'h100), TIMEOUT, TIMEOUT + 1);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        rec_t r;
        ack_en = 1'b0;
        @(negedge CLK50MHZ);
        cpu_q.push_back(mk_req(1'b0, 21'h00100, 8'h00));
        wait_quiet(400, ok);
        tests++;
        if (!ok || comp_q.size() != 1) begin
            fails++;
            $display("FAIL timeout_done: got quiet=%0b records=%0d, want 1/1", ok, comp_q.size());
        end else begin
            r = comp_q.pop_front();
            tests++;
            if (r.rdata[7:0] !== 8'hFF || ERR !== 1'b1 || r.mreq != TIMEOUT || r.lat != TIMEOUT + 1) begin
                fails++;
                $display("FAIL timeout: got dout=%h err=%b mreq_cycles=%0d lat=%0d, want ff/1/%0d/%0d",
                         r.rdata[7:0], ERR, r.mreq, r.lat, TIMEOUT, TIMEOUT + 1);
            end
        end
        ack_en = 1'b1; rand_delay = 1'b1;
        vid_q.push_back(mk_req(1'b0, 21'h00080, 8'h00));
        wait_quiet(60, ok);
        tests++;
        if (!ok || comp_q.size() != 1 || comp_q[0].rdata !== {refb(32'h100), refb(32'h101)} || ERR !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got quiet=%0b records=%0d err=%b, want 1/1/1 with correct data", ok, comp_q.size(), ERR);
        end
        comp_q.delete();
    endtask

    task automatic test_reset_busy();
        bit ok;
        ack_en = 1'b0;
        @(negedge CLK50MHZ);
        cpu_q.push_back(mk_req(1'b0, 21'h00101, 8'h00));
        repeat (20) @(negedge CLK50MHZ);
        tests++;
        if (MEM_REQ !== 1'b1) begin
            fails++;
            $display("FAIL busy_before_reset: got mem_req=%b, want 1", MEM_REQ);
        end
        COCO_RESET_N = 1'b0;
        #1;
        tests++;
        if (MEM_REQ !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: got mem_req=%b err=%b, want 0/0", MEM_REQ, ERR);
        end
        cpu_q.delete(); CPU_REQ = 1'b0; comp_q.delete();
        @(negedge CLK50MHZ);
        COCO_RESET_N = 1'b1;
        ack_en = 1'b1;
        cpu_q.push_back(mk_req(1'b0, 21'h00101, 8'h00));
        wait_quiet(60, ok);
        tests++;
        if (!ok || comp_q.size() != 1 || comp_q[0].rdata[7:0] !== refb(32'h101) || ERR !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_read: got quiet=%0b records=%0d err=%b, want 1/1/0 with data %h", ok, comp_q.size(), ERR, refb(32'h101));
        end
        comp_q.delete();
    endtask

    initial begin : watchdog
        #4ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_vid_priority();
        test_starvation();
        test_random_traffic();
        test_ack_on_timeout();
        test_timeout();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
